// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects N_BTN raw push-buttons.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   btn_raw      raw asynchronous button pins
//   btn_level    debounced level (registered)
//   btn_press    one-cycle pulse per debounced 0->1 edge (plus auto-repeat pulses)
//   btn_release  one-cycle pulse per debounced 1->0 edge
//
// Optional feature macro: BTN_COND_AUTOREPEAT_EN
//   When defined, a held button emits extra btn_press pulses, the first
//   REPEAT_DELAY_CYC cycles after the press and then every REPEAT_PERIOD_CYC cycles.
module btn_conditioner #(
    parameter int unsigned FREQ_OF_CLK_IN    = 100,
    parameter int unsigned DEBOUNCE_US       = 10000,
    parameter int unsigned N_BTN             = 2,
    parameter int unsigned REPEAT_DELAY_CYC  = 50000000,
    parameter int unsigned REPEAT_PERIOD_CYC = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned     DB_CYCLES = FREQ_OF_CLK_IN * DEBOUNCE_US;
    localparam int unsigned     DB_W      = (DB_CYCLES >= 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);

    // Elaboration-time sanity check of the configuration.
    if (DB_CYCLES < 2 || REPEAT_DELAY_CYC < 2 || REPEAT_PERIOD_CYC < 2) begin : g_param_check
        $error("btn_conditioner: DB_CYCLES and REPEAT_* cycle counts must be >= 2");
    end

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] db_done_c;   // stable long enough: level flips this edge
    logic [N_BTN-1:0] rpt_due_c;   // auto-repeat pulse due this edge

    // Two-flop synchronizer; the only sampling point of btn_raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debounce terminal-count detect.
    always_comb begin
        db_done_c = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            db_done_c[i] = (s2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Debounce counters and debounced level; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
            btn_level <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if ((s2[i] == btn_level[i]) || db_done_c[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
                if (db_done_c[i]) begin
                    btn_level[i] <= ~btn_level[i];
                end
            end
        end
    end

    // Edge pulses; a release on the same edge as a due repeat suppresses the repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= (db_done_c & ~btn_level) | (rpt_due_c & ~db_done_c);
            btn_release <= db_done_c & btn_level;
        end
    end

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam int unsigned      RPT_SPAN  = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                             REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int unsigned      RPT_W     = (RPT_SPAN >= 2) ? $clog2(RPT_SPAN) : 1;
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD_CYC - 1);

    logic [RPT_W-1:0] rpt_cnt [N_BTN];
    logic [N_BTN-1:0] rpt_armed;   // first repeat already issued for this hold

    // Repeat due when the held time reaches the delay (first) or the period (later).
    always_comb begin
        rpt_due_c = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            rpt_due_c[i] = btn_level[i] &&
                           (rpt_cnt[i] == (rpt_armed[i] ? RPT_NEXT : RPT_FIRST));
        end
    end

    // Repeat counters: idle while released, restart on every level change and repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                rpt_cnt[i] <= '0;
            end
            rpt_armed <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (!btn_level[i] || db_done_c[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (rpt_due_c[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
                end
            end
        end
    end
`else
    assign rpt_due_c = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed vector table, multi-cycle
// corner sequences and randomized stimulus against a window-based reference model.
module tb_btn_conditioner;

    localparam int unsigned NB = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    btn_conditioner #(
        .FREQ_OF_CLK_IN   (1),
        .DEBOUNCE_US      (4),
        .N_BTN            (NB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_PERIOD_CYC(RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: level flips once the last DB synchronized samples all disagree with it.
    logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    logic          m_win [NB][DB];
    int            m_held [NB];

    int p0_q[$];
    int r0_q[$];
    int lvl0_hits;

    typedef struct {
        logic          rst;
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic r, input logic [1:0] raw, input logic [1:0] lvl,
                                input logic [1:0] prs, input logic [1:0] rel);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d got lvl/prs/rel=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NB-1:0] raw);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int b = 0; b < NB; b++) begin
                m_held[b] = 0;
                for (int d = 0; d < DB; d++) m_win[b][d] = 1'b0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                logic all_diff;
                for (int d = DB - 1; d > 0; d--) m_win[b][d] = m_win[b][d-1];
                m_win[b][0] = m_s2[b];
                all_diff = 1'b1;
                for (int d = 0; d < DB; d++) if (m_win[b][d] == m_level[b]) all_diff = 1'b0;
                m_press[b] = 1'b0;
                m_rel[b]   = 1'b0;
                if (all_diff) begin
                    if (m_level[b]) m_rel[b] = 1'b1;
                    else begin
                        m_press[b] = 1'b1;
                        m_held[b]  = 0;
                    end
                    m_level[b] = ~m_level[b];
                end else if (m_level[b]) begin
                    m_held[b]++;
`ifdef BTN_COND_AUTOREPEAT_EN
                    if (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RP == 0))
                        m_press[b] = 1'b1;
`endif
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    // One clock edge: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [NB-1:0] raw);
        @(negedge clk);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        #1;
        model_edge(r, raw);
        check("model", {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
        if (btn_press[0])   p0_q.push_back(cyc);
        if (btn_release[0]) r0_q.push_back(cyc);
        if (btn_level[0])   lvl0_hits++;
        cyc++;
    endtask

    task automatic reset_and_clear();
        step(1'b1, '0);
        step(1'b1, '0);
        p0_q.delete();
        r0_q.delete();
        lvl0_hits = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m;
        int exp_q[$];
        logic [NB-1:0] cur;

        // Reset with both buttons held, then a clean release.
        for (int i = 0; i < 3; i++)   vt[i] = mk(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        for (int i = 3; i < 8; i++)   vt[i] = mk(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
        vt[8] = mk(1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
        vt[9] = mk(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
        for (int i = 10; i < 15; i++) vt[i] = mk(1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
        vt[15] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
        vt[16] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].rst, vt[i].raw);
            check($sformatf("vec%0d", i), {btn_level, btn_press, btn_release},
                  {vt[i].lvl, vt[i].prs, vt[i].rel});
        end

        // Clean press/release on bit 1 only.
        reset_and_clear();
        s = cyc;
        repeat (30) step(1'b0, 2'b10);
        repeat (8)  step(1'b0, 2'b00);
        check_int("clean1_level_after", int'(btn_level[1]), 0);

        // Glitch of 3 cycles never reaches the output.
        reset_and_clear();
        repeat (3)  step(1'b0, 2'b01);
        repeat (10) step(1'b0, 2'b00);
        check_int("glitch_press", p0_q.size(), 0);
        check_int("glitch_release", r0_q.size(), 0);
        check_int("glitch_level", lvl0_hits, 0);

        // Bounce every 2 cycles, then settle high at edge m.
        reset_and_clear();
        for (int t = 0; t < 12; t++) step(1'b0, {1'b0, ((t / 2) % 2 == 0)});
        m = cyc;
        repeat (15) step(1'b0, 2'b01);
        check_int("bounce_press_count", p0_q.size(), 1);
        if (p0_q.size() > 0) check_int("bounce_press_edge", p0_q[0] - m, 5);
        check_int("bounce_release_count", r0_q.size(), 0);
        repeat (10) step(1'b0, 2'b00);

        // Reset mid-count discards the partial count.
        reset_and_clear();
        repeat (3) step(1'b0, 2'b01);
        step(1'b1, 2'b01);
        s = cyc;
        repeat (8) step(1'b0, 2'b01);
        check_int("midreset_press_count", p0_q.size(), 1);
        if (p0_q.size() > 0) check_int("midreset_press_edge", p0_q[0] - s, 5);

        // 60-cycle hold: auto-repeat pulses when enabled; release coincides with a due repeat.
        reset_and_clear();
        s = cyc;
        repeat (60) step(1'b0, 2'b01);
        repeat (10) step(1'b0, 2'b00);
`ifdef BTN_COND_AUTOREPEAT_EN
        exp_q = '{0, 20, 28, 36, 44, 52};
`else
        exp_q = '{0};
`endif
        check_int("hold_press_count", p0_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < p0_q.size()) check_int($sformatf("hold_press%0d_edge", k), p0_q[k] - s, exp_q[k] + 5);
        end
        check_int("hold_release_count", r0_q.size(), 1);
        if (r0_q.size() > 0) check_int("hold_release_edge", r0_q[0] - s, 65);

        // Randomized stimulus with alternating fast-bounce and slow-hold phases.
        reset_and_clear();
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            int unsigned rate;
            rate = ((n / 400) % 2 == 1) ? 40 : 5;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, rate) == 0) cur[b] = ~cur[b];
            end
            step(($urandom_range(0, 499) == 0), cur);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
